ex_control_unit: RTL and testbench



---
 rtl/ex_control_unit_if.sv | 25 ++
 rtl/ex_control_unit.sv | 115 +++++++++++
 tb/tb_ex_control_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_control_unit_if.sv
// Bundle between the main controller FSM and the execute-stage control decoder.
// The master drives the instruction fields, and the slave returns the decoded EX controls.
interface ex_control_unit_if #(
  parameter int ifuresctl_N = 2
);
  localparam int SEL_W = (ifuresctl_N > 1) ? $clog2(ifuresctl_N) : 1;

  logic [6:0]       opcode;
  logic [2:0]       func3;
  logic [1:0]       func7b50;
  logic [3:0]       aluctl;
  logic [1:0]       mulctl;
  logic [SEL_W-1:0] ifuresctl;
  logic             mulstart;

  modport master (
    output opcode, func3, func7b50,
    input  aluctl, mulctl, ifuresctl, mulstart
  );

  modport slave (
    input  opcode, func3, func7b50,
    output aluctl, mulctl, ifuresctl, mulstart
  );
endinterface

// File: rtl/ex_control_unit.sv
// Execute-stage control decoder for the multi-cycle RV32IM core.
// The decode is combinational, and a small tracker turns a held multiply into a single start pulse.
module ex_control_unit #(
  parameter int ifuresctl_N = 2
) (
  input logic              clk,
  input logic              rst,
  ex_control_unit_if.slave bus
);
  localparam int SEL_W = (ifuresctl_N > 1) ? $clog2(ifuresctl_N) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_SLT   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_XOR   = 4'b0101;
  localparam logic [3:0] ALU_SRL   = 4'b0110;
  localparam logic [3:0] ALU_SRA   = 4'b0111;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_AND   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic [3:0]  alu_op;
  logic [1:0]  mul_op;
  logic        sel_mul;
  logic        is_mul;
  logic [11:0] key;
  logic        prev_mul_reg;
  logic [11:0] prev_key_reg;

  // The plain R-type func3 map is shared with the I-ALU group.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    logic [3:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    alu_op  = ALU_ADD;
    mul_op  = 2'b00;
    sel_mul = 1'b0;
    case (bus.opcode)
      OP_R: begin
        case (bus.func7b50)
          2'b00: alu_op = base_alu(bus.func3);
          2'b10: begin
            if (bus.func3 == 3'b000)
              alu_op = ALU_SUB;
            else if (bus.func3 == 3'b101)
              alu_op = ALU_SRA;
          end
          2'b01: begin
            // Only the MUL family is handled here; div/rem fall through to the default.
            if (!bus.func3[2]) begin
              mul_op  = bus.func3[1:0];
              sel_mul = 1'b1;
            end
          end
          default: ;
        endcase
      end
      OP_I: begin
        if (bus.func3 == 3'b101 && bus.func7b50[1])
          alu_op = ALU_SRA;
        else
          alu_op = base_alu(bus.func3);
      end
      OP_LUI: alu_op = ALU_PASSB;
      OP_BRANCH: begin
        case (bus.func3)
          3'b000, 3'b001: alu_op = ALU_SUB;
          3'b100, 3'b101: alu_op = ALU_SLT;
          3'b110, 3'b111: alu_op = ALU_SLTU;
          default:        alu_op = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  assign is_mul = (bus.opcode == OP_R) && (bus.func7b50 == 2'b01) && !bus.func3[2];
  assign key    = {bus.opcode, bus.func3, bus.func7b50};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_mul_reg <= 1'b0;
      prev_key_reg <= 12'd0;
    end else begin
      prev_mul_reg <= is_mul;
      prev_key_reg <= key;
    end
  end

  // A multiply held across cycles starts the multiplier only once.
  // A change of encoding or a reset re-arms the start pulse.
  assign bus.mulstart  = is_mul & ~(prev_mul_reg & (key == prev_key_reg));
  assign bus.aluctl    = alu_op;
  assign bus.mulctl    = mul_op;
  assign bus.ifuresctl = SEL_W'(sel_mul);
endmodule

// File: tb/tb_ex_control_unit.sv
// Randomized and directed checks of ex_control_unit against a behavioural decode model.
module tb_ex_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  ex_control_unit_if #(.ifuresctl_N(2)) bus();
  ex_control_unit #(.ifuresctl_N(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // The model tracks which encoding was present in the previous cycle.
  logic        m_prev_mul = 1'b0;
  logic [11:0] m_prev_key = 12'd0;

  function automatic logic is_mul(input logic [6:0] o, input logic [2:0] f, input logic [1:0] s);
    return (o == 7'b0110011) && (s == 2'b01) && (f < 3'd4);
  endfunction

  function automatic logic [3:0] exp_alu(input logic [6:0] o, input logic [2:0] f, input logic [1:0] s);
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (o == 7'b0110011) begin
      if (s == 2'b00) return base[f];
      if (s == 2'b10 && f == 3'd0) return 4'd1;
      if (s == 2'b10 && f == 3'd5) return 4'd7;
      return 4'd0;
    end
    if (o == 7'b0010011) begin
      if (f == 3'd5) return s[1] ? 4'd7 : 4'd6;
      return base[f];
    end
    if (o == 7'b0110111) return 4'd10;
    if (o == 7'b1100011) begin
      if (f <= 3'd1) return 4'd1;
      if (f == 3'd4 || f == 3'd5) return 4'd3;
      if (f >= 3'd6) return 4'd4;
    end
    return 4'd0;
  endfunction

  function automatic logic [1:0] exp_mulctl(input logic [6:0] o, input logic [2:0] f, input logic [1:0] s);
    return is_mul(o, f, s) ? f[1:0] : 2'b00;
  endfunction

  function automatic logic exp_start(input logic [6:0] o, input logic [2:0] f, input logic [1:0] s);
    return is_mul(o, f, s) && !(m_prev_mul && ({o, f, s} == m_prev_key));
  endfunction

  // This task advances one clock, drives a new instruction, and stops on the next falling edge.
  task automatic apply(input logic [6:0] o, input logic [2:0] f, input logic [1:0] s);
    @(posedge clk);
    if (!rst) begin
      m_prev_mul = is_mul(bus.opcode, bus.func3, bus.func7b50);
      m_prev_key = {bus.opcode, bus.func3, bus.func7b50};
    end
    #1;
    bus.opcode   = o;
    bus.func3    = f;
    bus.func7b50 = s;
    @(negedge clk);
    $display("txn op=%b f3=%b f7=%b alu=%b mul=%b sel=%0d start=%b",
             o, f, s, bus.aluctl, bus.mulctl, bus.ifuresctl, bus.mulstart);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.opcode = 7'b0110011; bus.func3 = 3'b000; bus.func7b50 = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total += 3;
    if (bus.aluctl !== 4'b0000) begin bad++; $display("FAIL reset_alu got=%b want=0000", bus.aluctl); end
    if (bus.ifuresctl !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b want=0", bus.ifuresctl); end
    if (bus.mulstart !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", bus.mulstart); end
  endtask

  task automatic test_rtype();
    logic [3:0] want [4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0110};
    logic [2:0] f3s  [4] = '{3'b000, 3'b000, 3'b101, 3'b101};
    logic [1:0] f7s  [4] = '{2'b00, 2'b10, 2'b10, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply(7'b0110011, f3s[i], f7s[i]);
      total += 3;
      if (bus.aluctl !== want[i]) begin bad++; $display("FAIL rtype_alu i=%0d got=%b want=%b", i, bus.aluctl, want[i]); end
      if (bus.aluctl !== exp_alu(7'b0110011, f3s[i], f7s[i])) begin bad++; $display("FAIL rtype_model i=%0d got=%b", i, bus.aluctl); end
      if (bus.ifuresctl !== 1'b0 || bus.mulstart !== 1'b0) begin bad++; $display("FAIL rtype_mul i=%0d sel=%b start=%b want 0/0", i, bus.ifuresctl, bus.mulstart); end
    end
  endtask

  task automatic test_itype();
    logic [3:0] want [4] = '{4'b0000, 4'b0111, 4'b0110, 4'b1000};
    logic [2:0] f3s  [4] = '{3'b000, 3'b101, 3'b101, 3'b110};
    logic [1:0] f7s  [4] = '{2'b10, 2'b10, 2'b00, 2'b11};
    for (int i = 0; i < 4; i++) begin
      apply(7'b0010011, f3s[i], f7s[i]);
      total += 2;
      if (bus.aluctl !== want[i]) begin bad++; $display("FAIL itype_alu i=%0d got=%b want=%b", i, bus.aluctl, want[i]); end
      if (bus.mulctl !== 2'b00 || bus.ifuresctl !== 1'b0) begin bad++; $display("FAIL itype_mul i=%0d mul=%b sel=%b want 00/0", i, bus.mulctl, bus.ifuresctl); end
    end
  endtask

  task automatic test_mul();
    logic [2:0] f3s  [6] = '{3'b011, 3'b011, 3'b011, 3'b001, 3'b000, 3'b001};
    logic [1:0] f7s  [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
    logic       want [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      apply(7'b0110011, f3s[i], f7s[i]);
      total += 4;
      if (bus.mulstart !== want[i]) begin bad++; $display("FAIL mul_start i=%0d got=%b want=%b", i, bus.mulstart, want[i]); end
      if (bus.mulctl !== exp_mulctl(7'b0110011, f3s[i], f7s[i])) begin bad++; $display("FAIL mul_ctl i=%0d got=%b want=%b", i, bus.mulctl, exp_mulctl(7'b0110011, f3s[i], f7s[i])); end
      if (bus.ifuresctl !== is_mul(7'b0110011, f3s[i], f7s[i])) begin bad++; $display("FAIL mul_sel i=%0d got=%b", i, bus.ifuresctl); end
      if (bus.aluctl !== 4'b0000) begin bad++; $display("FAIL mul_alu i=%0d got=%b want=0000", i, bus.aluctl); end
    end
  endtask

  task automatic test_branch_misc();
    logic [6:0] ops  [9] = '{7'b1100011, 7'b1100011, 7'b1100011, 7'b0110111, 7'b0000011,
                             7'b0100011, 7'b1101111, 7'b1100111, 7'b0010111};
    logic [2:0] f3s  [9] = '{3'b000, 3'b101, 3'b111, 3'b011, 3'b010, 3'b010, 3'b101, 3'b000, 3'b110};
    logic [3:0] want [9] = '{4'b0001, 4'b0011, 4'b0100, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      apply(ops[i], f3s[i], 2'($urandom_range(0, 3)));
      total += 2;
      if (bus.aluctl !== want[i]) begin bad++; $display("FAIL misc_alu op=%b got=%b want=%b", ops[i], bus.aluctl, want[i]); end
      if (bus.ifuresctl !== 1'b0 || bus.mulstart !== 1'b0) begin bad++; $display("FAIL misc_mul op=%b sel=%b start=%b want 0/0", ops[i], bus.ifuresctl, bus.mulstart); end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops [4] = '{7'b1111111, 7'b0110011, 7'b0110011, 7'b1100011};
    logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b100, 3'b010};
    logic [1:0] f7s [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      apply(ops[i], f3s[i], f7s[i]);
      total += 4;
      if (bus.aluctl !== 4'b0000) begin bad++; $display("FAIL illegal_alu i=%0d got=%b want=0000", i, bus.aluctl); end
      if (bus.mulctl !== 2'b00) begin bad++; $display("FAIL illegal_mul i=%0d got=%b want=00", i, bus.mulctl); end
      if (bus.ifuresctl !== 1'b0) begin bad++; $display("FAIL illegal_sel i=%0d got=%b want=0", i, bus.ifuresctl); end
      if (bus.mulstart !== 1'b0) begin bad++; $display("FAIL illegal_start i=%0d got=%b want=0", i, bus.mulstart); end
    end
  endtask

  task automatic test_async_reset();
    apply(7'b0110011, 3'b010, 2'b01);
    apply(7'b0110011, 3'b010, 2'b01);
    total += 1;
    if (bus.mulstart !== 1'b0) begin bad++; $display("FAIL held_start got=%b want=0", bus.mulstart); end
    #2;
    rst = 1'b1;
    m_prev_mul = 1'b0;
    m_prev_key = 12'd0;
    #1;
    total += 1;
    if (bus.mulstart !== 1'b1) begin bad++; $display("FAIL async_rst_start got=%b want=1", bus.mulstart); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    total += 1;
    if (bus.mulstart !== 1'b1) begin bad++; $display("FAIL release_start got=%b want=1", bus.mulstart); end
    apply(7'b0110011, 3'b010, 2'b01);
    total += 1;
    if (bus.mulstart !== 1'b0) begin bad++; $display("FAIL after_release_start got=%b want=0", bus.mulstart); end
  endtask

  task automatic test_random();
    logic [6:0] legal [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1101111,
                               7'b1100111, 7'b0010111, 7'b0110111, 7'b1100011, 7'b0110011};
    logic [6:0] o;
    logic [2:0] f;
    logic [1:0] s;
    logic [3:0] e_alu;
    logic [1:0] e_mul;
    logic       e_start;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin o = 7'b0110011; f = 3'($urandom_range(0, 4)); s = 2'b01; end
        2:    begin o = legal[$urandom_range(0, 9)]; f = 3'($urandom); s = 2'($urandom); end
        default: begin o = 7'($urandom); f = 3'($urandom); s = 2'($urandom); end
      endcase
      apply(o, f, s);
      e_alu   = exp_alu(o, f, s);
      e_mul   = exp_mulctl(o, f, s);
      e_start = exp_start(o, f, s);
      total += 4;
      if (bus.aluctl !== e_alu) begin bad++; $display("FAIL rand_alu op=%b f3=%b f7=%b got=%b want=%b", o, f, s, bus.aluctl, e_alu); end
      if (bus.mulctl !== e_mul) begin bad++; $display("FAIL rand_mul op=%b f3=%b f7=%b got=%b want=%b", o, f, s, bus.mulctl, e_mul); end
      if (bus.ifuresctl !== is_mul(o, f, s)) begin bad++; $display("FAIL rand_sel op=%b f3=%b f7=%b got=%b want=%b", o, f, s, bus.ifuresctl, is_mul(o, f, s)); end
      if (bus.mulstart !== e_start) begin bad++; $display("FAIL rand_start op=%b f3=%b f7=%b got=%b want=%b", o, f, s, bus.mulstart, e_start); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_mul();
    test_branch_misc();
    test_illegal();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
